// File: rtl/qam_spi_ctrl.sv
// SPI-slave register interface for the 64-QAM modulator: decodes 16-bit frames,
// holds enable/gain/divider/status registers and times the soft-reset pulse.
module qam_spi_ctrl #(
  parameter int          SOFT_RST_CYCLES = 4,
  parameter logic [7:0]  ID_VALUE        = 8'hA6
) (
  input  logic       SCLK,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  input  logic       err_in,
  output logic       mod_en,
  output logic       soft_rst_n,
  output logic [5:0] gain,
  output logic [7:0] sym_div,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [7:0] SRST_LOAD = 8'(SOFT_RST_CYCLES);

  state_t     state_reg, state_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic       rw_reg, rw_next;
  logic [6:0] addr_reg, addr_next;
  logic [6:0] data_reg, data_next;
  logic [7:0] rd_sr_reg, rd_sr_next;
  logic       miso_reg, miso_next;
  logic       frame_done_reg, frame_done_next;
  logic       mod_en_reg, mod_en_next;
  logic [5:0] gain_reg, gain_next;
  logic [7:0] sym_div_reg, sym_div_next;
  logic [1:0] status_reg, status_next;
  logic [7:0] srst_cnt_reg, srst_cnt_next;
  logic       soft_rst_n_reg, soft_rst_n_next;

  logic [6:0] addr_full;
  logic [7:0] wr_data;
  logic [7:0] rd_mux;
  logic       commit;
  logic       abort;
  logic [1:0] w1c;
  logic       srst_active;

  // Address/data words including the bit being sampled on this edge.
  assign addr_full   = {addr_reg[5:0], mosi};
  assign wr_data     = {data_reg, mosi};
  assign srst_active = (srst_cnt_reg != 8'd0);

  always_comb begin
    rd_mux = 8'h00;
    case (addr_full)
      7'h00:   rd_mux = {7'b0, mod_en_reg};
      7'h01:   rd_mux = {2'b0, gain_reg};
      7'h02:   rd_mux = sym_div_reg;
      7'h03:   rd_mux = {6'b0, status_reg};
      7'h7F:   rd_mux = ID_VALUE;
      default: rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    rw_next         = rw_reg;
    addr_next       = addr_reg;
    data_next       = data_reg;
    rd_sr_next      = rd_sr_reg;
    miso_next       = miso_reg;
    frame_done_next = 1'b0;
    commit          = 1'b0;
    abort           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!cs_n) begin
          rw_next      = mosi;
          bit_cnt_next = 4'd1;
          state_next   = ADDR;
        end
      end
      ADDR: begin
        if (cs_n) begin
          abort      = 1'b1;
          miso_next  = 1'b0;
          state_next = IDLE;
        end else begin
          addr_next    = addr_full;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd7) begin
            // Snapshot of the addressed register; later updates stay out of this frame.
            miso_next  = rd_mux[7];
            rd_sr_next = {rd_mux[6:0], 1'b0};
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (cs_n) begin
          abort      = 1'b1;
          miso_next  = 1'b0;
          state_next = IDLE;
        end else begin
          data_next    = wr_data[6:0];
          miso_next    = rd_sr_reg[7];
          rd_sr_next   = {rd_sr_reg[6:0], 1'b0};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd15) begin
            commit          = rw_reg;
            frame_done_next = 1'b1;
            miso_next       = 1'b0;
            state_next      = DONE;
          end
        end
      end
      DONE: begin
        if (cs_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mod_en_next   = mod_en_reg;
    gain_next     = gain_reg;
    sym_div_next  = sym_div_reg;
    w1c           = 2'b00;
    srst_cnt_next = srst_active ? srst_cnt_reg - 8'd1 : 8'd0;

    if (commit) begin
      case (addr_reg)
        7'h00: begin
          if (!srst_active) begin
            if (wr_data[1]) begin
              mod_en_next   = 1'b0;
              srst_cnt_next = SRST_LOAD;
            end else begin
              mod_en_next = wr_data[0];
            end
          end
        end
        7'h01:   gain_next    = wr_data[5:0];
        7'h02:   sym_div_next = (wr_data == 8'd0) ? 8'd1 : wr_data;
        7'h03:   w1c          = wr_data[1:0];
        default: ;
      endcase
    end

    // Sticky sets win over a same-cycle write-1-to-clear.
    status_next     = (status_reg & ~w1c) | {abort, err_in};
    soft_rst_n_next = (srst_cnt_next == 8'd0);
  end

  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= 4'd0;
      rw_reg         <= 1'b0;
      addr_reg       <= 7'd0;
      data_reg       <= 7'd0;
      rd_sr_reg      <= 8'd0;
      miso_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      mod_en_reg     <= 1'b0;
      gain_reg       <= 6'd32;
      sym_div_reg    <= 8'd8;
      status_reg     <= 2'b00;
      srst_cnt_reg   <= 8'd0;
      soft_rst_n_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      rw_reg         <= rw_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      rd_sr_reg      <= rd_sr_next;
      miso_reg       <= miso_next;
      frame_done_reg <= frame_done_next;
      mod_en_reg     <= mod_en_next;
      gain_reg       <= gain_next;
      sym_div_reg    <= sym_div_next;
      status_reg     <= status_next;
      srst_cnt_reg   <= srst_cnt_next;
      soft_rst_n_reg <= soft_rst_n_next;
    end
  end

  assign miso       = miso_reg;
  assign frame_done = frame_done_reg;
  assign mod_en     = mod_en_reg;
  assign gain       = gain_reg;
  assign sym_div    = sym_div_reg;
  assign soft_rst_n = soft_rst_n_reg;

endmodule

// File: tb/tb_qam_spi_ctrl.sv
// Directed bench for qam_spi_ctrl; a second instance with a long soft-reset window
// shares the inputs so a CTRL write can land inside an active soft reset.
module tb_qam_spi_ctrl;

  logic SCLK = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic err_in = 1'b0;

  logic       miso, mod_en, soft_rst_n, frame_done;
  logic [5:0] gain;
  logic [7:0] sym_div;
  logic       l_miso, l_mod_en, l_soft_rst_n, l_frame_done;
  logic [5:0] l_gain;
  logic [7:0] l_sym_div;

  int checks = 0;
  int errors = 0;
  int low_cnt = 0;
  int l_low_cnt = 0;
  logic cnt_clr = 1'b0;
  logic [7:0] rd;

  always #5 SCLK = ~SCLK;

  qam_spi_ctrl dut (
    .SCLK(SCLK), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .err_in(err_in), .mod_en(mod_en), .soft_rst_n(soft_rst_n),
    .gain(gain), .sym_div(sym_div), .frame_done(frame_done)
  );

  qam_spi_ctrl #(.SOFT_RST_CYCLES(24)) dut_long (
    .SCLK(SCLK), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi), .miso(l_miso),
    .err_in(err_in), .mod_en(l_mod_en), .soft_rst_n(l_soft_rst_n),
    .gain(l_gain), .sym_div(l_sym_div), .frame_done(l_frame_done)
  );

  always @(negedge SCLK) begin
    if (cnt_clr) begin
      low_cnt   <= 0;
      l_low_cnt <= 0;
    end else begin
      if (!soft_rst_n)   low_cnt   <= low_cnt + 1;
      if (!l_soft_rst_n) l_low_cnt <= l_low_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full frame; inputs change on falling edges, miso captured before each data bit.
  task automatic xfer(input logic [15:0] frame, input logic err_last, output logic [7:0] rdata);
    rdata = 8'h00;
    for (int k = 0; k < 16; k++) begin
      @(negedge SCLK);
      if (k >= 8) rdata[15-k] = miso;
      cs_n   = 1'b0;
      mosi   = frame[15-k];
      err_in = err_last && (k == 15);
    end
    @(negedge SCLK);
    check("frame_done_hi", frame_done, 1);
    check("l_frame_done_hi", l_frame_done, 1);
    cs_n   = 1'b1;
    mosi   = 1'b0;
    err_in = 1'b0;
    @(negedge SCLK);
    check("frame_done_lo", frame_done, 0);
    $display("xfer frame=%h rd=%h", frame, rdata);
  endtask

  task automatic xfer_abort(input logic [15:0] frame, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      @(negedge SCLK);
      cs_n = 1'b0;
      mosi = frame[15-k];
    end
    @(negedge SCLK);
    cs_n = 1'b1;
    mosi = 1'b0;
    @(negedge SCLK);
    check("abort_no_done", frame_done, 0);
    $display("abort frame=%h after %0d bits", frame, nbits);
  endtask

  initial begin
    // 1: reset values
    repeat (3) @(negedge SCLK);
    rst_n = 1'b1;
    repeat (10) @(negedge SCLK);
    check("rst_mod_en", mod_en, 0);
    check("rst_soft_rst_n", soft_rst_n, 1);
    check("rst_gain", gain, 32);
    check("rst_sym_div", sym_div, 8);
    check("rst_miso", miso, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_l_outputs", {l_mod_en, l_soft_rst_n, l_gain, l_sym_div, l_miso}, {1'b0, 1'b1, 6'd32, 8'd8, 1'b0});

    // 2: gain write and read-back
    xfer(16'h8115, 1'b0, rd);
    check("gain_after_write", gain, 6'h15);
    xfer(16'h0100, 1'b0, rd);
    check("gain_readback", rd, 8'h15);

    // 3: soft reset; the long instance still has it active during the second CTRL write
    xfer(16'h8001, 1'b0, rd);
    check("mod_en_set", mod_en, 1);
    check("l_mod_en_set", l_mod_en, 1);
    cnt_clr = 1'b1;
    repeat (2) @(negedge SCLK);
    cnt_clr = 1'b0;
    xfer(16'h8003, 1'b0, rd);
    check("srst_mod_en", mod_en, 0);
    check("srst_l_mod_en", l_mod_en, 0);
    check("srst_active", soft_rst_n, 0);
    xfer(16'h8001, 1'b0, rd);
    check("ctrl_after_window", mod_en, 1);
    check("ctrl_in_window_ignored", l_mod_en, 0);
    check("l_srst_still_active", l_soft_rst_n, 0);
    check("srst_released", soft_rst_n, 1);
    repeat (12) @(negedge SCLK);
    check("srst_low_cycles", low_cnt, 4);
    check("l_srst_low_cycles", l_low_cnt, 24);
    check("l_srst_released", l_soft_rst_n, 1);
    check("gain_kept", gain, 6'h15);
    xfer(16'h0000, 1'b0, rd);
    check("ctrl_read", rd, 8'h01);

    // 4: aborted frame
    xfer_abort(16'h8255, 10);
    check("abort_sym_div", sym_div, 8);
    xfer(16'h0300, 1'b0, rd);
    check("status_frame_err", rd, 8'h02);
    xfer(16'h8302, 1'b0, rd);
    xfer(16'h0300, 1'b0, rd);
    check("status_cleared", rd, 8'h00);

    // 5: err sticky and set-over-clear priority
    @(negedge SCLK) err_in = 1'b1;
    @(negedge SCLK) err_in = 1'b0;
    xfer(16'h0300, 1'b0, rd);
    check("status_err", rd, 8'h01);
    xfer(16'h8301, 1'b1, rd);
    xfer(16'h0300, 1'b0, rd);
    check("status_set_wins", rd, 8'h01);
    xfer(16'h8301, 1'b0, rd);
    xfer(16'h0300, 1'b0, rd);
    check("status_w1c", rd, 8'h00);

    // 6: ID, unmapped, divider floor, gain mask, async reset mid-frame
    xfer(16'h7F00, 1'b0, rd);
    check("id_read", rd, 8'hA6);
    xfer(16'h4000, 1'b0, rd);
    check("unmapped_read", rd, 8'h00);
    xfer(16'h8200, 1'b0, rd);
    check("sym_div_floor", sym_div, 1);
    xfer(16'h81FF, 1'b0, rd);
    check("gain_masked", gain, 6'h3F);
    xfer(16'h0100, 1'b0, rd);
    check("gain_read_mask", rd, 8'h3F);

    for (int k = 0; k < 10; k++) begin
      @(negedge SCLK);
      cs_n = 1'b0;
      mosi = (k == 0) ? 1'b0 : 1'b1;
    end
    @(negedge SCLK);
    check("midframe_miso_d5", miso, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_mod_en", mod_en, 0);
    check("arst_soft_rst_n", soft_rst_n, 1);
    check("arst_gain", gain, 32);
    check("arst_sym_div", sym_div, 8);
    check("arst_miso", miso, 0);
    check("arst_frame_done", frame_done, 0);
    cs_n = 1'b1;
    mosi = 1'b0;
    @(negedge SCLK);
    rst_n = 1'b1;
    @(negedge SCLK);
    xfer(16'h0100, 1'b0, rd);
    check("post_rst_gain_read", rd, 8'h20);
    xfer(16'h0200, 1'b0, rd);
    check("post_rst_sym_div_read", rd, 8'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
